// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side request ports and memory-side handshake for mem_port_arbiter.
// The arbiter sits on the slave modport; the CPU stages and the memory sit on master.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          start_i;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_ack_o;
  logic [DW-1:0] if_rdata_o;
  logic          if_stall_o;
  logic          dm_req_i;
  logic          dm_we_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_wdata_i;
  logic          dm_ack_o;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_stall_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ready_i;
  logic          err_o;

  modport slave (
    input  start_i, if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ready_i,
    output if_ack_o, if_rdata_o, if_stall_o, dm_ack_o, dm_rdata_o, dm_stall_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );

  modport master (
    output start_i, if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ready_i,
    input  if_ack_o, if_rdata_o, if_stall_o, dm_ack_o, dm_rdata_o, dm_stall_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port variable-latency memory between instruction fetch and the
// data stage: grants one access at a time, runs the handshake, returns data and stalls.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q,    state_d;
  logic          gnt_dm_q,   gnt_dm_d;
  logic          we_q,       we_d;
  logic [AW-1:0] addr_q,     addr_d;
  logic [DW-1:0] wdata_q,    wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic [TW-1:0] tmo_q,      tmo_d;
  logic [SW-1:0] starve_q,   starve_d;
  logic          err_q,      err_d;
  logic          pick_if;
  logic          if_ack;
  logic          dm_ack;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      gnt_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      tmo_q      <= '0;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_dm_q   <= gnt_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      tmo_q      <= tmo_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
    end
  end

  // Grant selection, memory handshake sequencing and response capture.
  always_comb begin
    state_d    = state_q;
    gnt_dm_d   = gnt_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    tmo_d      = tmo_q;
    starve_d   = starve_q;
    err_d      = err_q;
    pick_if    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i && (bus.if_req_i || bus.dm_req_i)) begin
          // Data stage holds the older instruction, so it wins unless fetch is starved.
          pick_if  = !bus.dm_req_i || (bus.if_req_i && (starve_q == SW'(STARVE_LIMIT)));
          gnt_dm_d = !pick_if;
          tmo_d    = '0;
          state_d  = S_BUSY;
          if (pick_if) begin
            we_d     = 1'b0;
            addr_d   = bus.if_addr_i;
            starve_d = '0;
          end else begin
            we_d    = bus.dm_we_i;
            addr_d  = bus.dm_addr_i;
            wdata_d = bus.dm_wdata_i;
            if (bus.if_req_i && (starve_q != SW'(STARVE_LIMIT))) begin
              starve_d = starve_q + SW'(1);
            end
          end
        end
      end
      S_BUSY: begin
        if (bus.mem_ready_i) begin
          if (!gnt_dm_q)  if_rdata_d = bus.mem_rdata_i;
          else if (!we_q) dm_rdata_d = bus.mem_rdata_i;
          state_d = S_RESP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Last allowed wait cycle: complete with zero data and flag the error.
          err_d = 1'b1;
          if (!gnt_dm_q)  if_rdata_d = '0;
          else if (!we_q) dm_rdata_d = '0;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign if_ack = (state_q == S_RESP) && !gnt_dm_q;
  assign dm_ack = (state_q == S_RESP) &&  gnt_dm_q;

  assign bus.if_ack_o    = if_ack;
  assign bus.dm_ack_o    = dm_ack;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.if_stall_o  = bus.if_req_i & ~if_ack;
  assign bus.dm_stall_o  = bus.dm_req_i & ~dm_ack;
  assign bus.mem_req_o   = (state_q == S_BUSY);
  assign bus.mem_we_o    = (state_q == S_BUSY) && we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level reference model checked
// every cycle, plus literal expectations on latency, grant order and data.
module tb_mem_port_arbiter;
  localparam int STARVE_LIMIT = 3;
  localparam int TIMEOUT      = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   rsp_delay = 0;
  int   bcnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h8C01_0000;
    return {a[15:0] ^ 16'h5A5A, 16'h1234 + a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: asserts ready after rsp_delay wait cycles of a request.
  initial begin
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #3;
      if (bus.mem_req_o) begin
        bus.mem_ready_i = (bcnt == rsp_delay);
        bus.mem_rdata_i = (bcnt == rsp_delay) ? mem_word(bus.mem_addr_o) : 32'hDEAD_BEEF;
        bcnt++;
      end else begin
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = 32'hDEAD_BEEF;
        bcnt = 0;
      end
    end
  end

  // Reference model: which requester owns the memory, how long it has waited,
  // and who is being acknowledged this cycle (1 = fetch, 2 = data).
  int          m_owner = 0;
  int          m_resp = 0;
  int          m_waited = 0;
  int          m_starve = 0;
  logic        m_we = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_if_rd = '0;
  logic [31:0] m_dm_rd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= 0;  m_resp <= 0;   m_waited <= 0; m_starve <= 0;
      m_we    <= 0;  m_err  <= 0;   m_addr   <= '0; m_wdata <= '0;
      m_if_rd <= '0; m_dm_rd <= '0;
    end else if (m_resp != 0) begin
      m_resp <= 0;
    end else if (m_owner != 0) begin
      if (bus.mem_ready_i || (m_waited + 1 == TIMEOUT)) begin
        if (!bus.mem_ready_i) m_err <= 1'b1;
        if (m_owner == 1)  m_if_rd <= bus.mem_ready_i ? bus.mem_rdata_i : 32'h0;
        else if (!m_we)    m_dm_rd <= bus.mem_ready_i ? bus.mem_rdata_i : 32'h0;
        m_resp  <= m_owner;
        m_owner <= 0;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (bus.start_i && (bus.if_req_i || bus.dm_req_i)) begin
      m_waited <= 0;
      if (!bus.dm_req_i || (bus.if_req_i && m_starve == STARVE_LIMIT)) begin
        m_owner  <= 1;
        m_we     <= 1'b0;
        m_addr   <= bus.if_addr_i;
        m_starve <= 0;
      end else begin
        m_owner <= 2;
        m_we    <= bus.dm_we_i;
        m_addr  <= bus.dm_addr_i;
        m_wdata <= bus.dm_wdata_i;
        if (bus.if_req_i && m_starve < STARVE_LIMIT) m_starve <= m_starve + 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("mem_req",   64'(bus.mem_req_o),   64'(m_owner != 0));
    chk("mem_we",    64'(bus.mem_we_o),    64'(m_owner == 2 && m_we));
    chk("mem_addr",  64'(bus.mem_addr_o),  64'(m_addr));
    chk("mem_wdata", 64'(bus.mem_wdata_o), 64'(m_wdata));
    chk("if_ack",    64'(bus.if_ack_o),    64'(m_resp == 1));
    chk("dm_ack",    64'(bus.dm_ack_o),    64'(m_resp == 2));
    chk("if_rdata",  64'(bus.if_rdata_o),  64'(m_if_rd));
    chk("dm_rdata",  64'(bus.dm_rdata_o),  64'(m_dm_rd));
    chk("err",       64'(bus.err_o),       64'(m_err));
    chk("if_stall",  64'(bus.if_stall_o),  64'(bus.if_req_i && m_resp != 1));
    chk("dm_stall",  64'(bus.dm_stall_o),  64'(bus.dm_req_i && m_resp != 2));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Advance until an ack appears; reports who, cycles taken, busy and write cycles seen.
  task automatic wait_ack(input int max, output int who, output int cyc,
                          output int busy_n, output int we_n);
    who = 0; cyc = 0; busy_n = 0; we_n = 0;
    while (who == 0 && cyc < max) begin
      step();
      cyc++;
      if (bus.mem_req_o) busy_n++;
      if (bus.mem_we_o)  we_n++;
      if (bus.dm_ack_o)      who = 2;
      else if (bus.if_ack_o) who = 1;
    end
    if (who == 0) chk("ack_wait_expired", 64'(0), 64'(1));
  endtask

  int who, cyc, busy_n, we_n, busy_cnt;

  initial begin
    bus.start_i = 1'b0; bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    #1 rst = 1'b1;
    step(); step();
    chk("rst_mem_req", 64'(bus.mem_req_o), 64'(0));
    chk("rst_err",     64'(bus.err_o),     64'(0));
    rst = 1'b0;
    step();

    // Fetch only, minimum latency.
    bus.start_i = 1'b1; bus.if_req_i = 1'b1; bus.if_addr_i = 32'h04; rsp_delay = 0;
    wait_ack(10, who, cyc, busy_n, we_n);
    chk("t1_who",   64'(who), 64'(1));
    chk("t1_lat",   64'(cyc), 64'(2));
    chk("t1_rdata", 64'(bus.if_rdata_o), 64'h8C01_0000);
    chk("t1_we",    64'(we_n), 64'(0));
    bus.if_req_i = 1'b0;
    step();

    // Simultaneous requests: data first, then fetch.
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h10;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h08;
    wait_ack(10, who, cyc, busy_n, we_n);
    chk("t2_first",    64'(who), 64'(2));
    chk("t2_dm_rdata", 64'(bus.dm_rdata_o), 64'(mem_word(32'h10)));
    chk("t2_if_stall", 64'(bus.if_stall_o), 64'(1));
    bus.dm_req_i = 1'b0;
    wait_ack(10, who, cyc, busy_n, we_n);
    chk("t2_second",   64'(who), 64'(1));
    chk("t2_lat",      64'(cyc), 64'(3));
    chk("t2_if_rdata", 64'(bus.if_rdata_o), 64'(mem_word(32'h08)));
    bus.if_req_i = 1'b0;
    step();

    // Starvation: with both held, three data grants then one fetch, repeating.
    bus.dm_req_i = 1'b1; bus.dm_addr_i = 32'h20; bus.if_req_i = 1'b1; bus.if_addr_i = 32'h24;
    for (int k = 0; k < 8; k++) begin
      wait_ack(10, who, cyc, busy_n, we_n);
      chk("t3_order", 64'(who), 64'(((k % 4) == 3) ? 1 : 2));
    end
    bus.dm_req_i = 1'b0; bus.if_req_i = 1'b0;
    step();

    // Store with four wait cycles.
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_addr_i = 32'h00;
    bus.dm_wdata_i = 32'h5; rsp_delay = 4;
    wait_ack(20, who, cyc, busy_n, we_n);
    chk("t4_who",      64'(who), 64'(2));
    chk("t4_lat",      64'(cyc), 64'(6));
    chk("t4_busy",     64'(busy_n), 64'(5));
    chk("t4_we",       64'(we_n), 64'(5));
    chk("t4_wdata",    64'(bus.mem_wdata_o), 64'h5);
    chk("t4_dm_rdata", 64'(bus.dm_rdata_o), 64'(mem_word(32'h20)));
    bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0;
    step();

    // Timeout: memory never answers.
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0C; rsp_delay = 99;
    wait_ack(30, who, cyc, busy_n, we_n);
    chk("t5_who",   64'(who), 64'(1));
    chk("t5_lat",   64'(cyc), 64'(16));
    chk("t5_busy",  64'(busy_n), 64'(15));
    chk("t5_rdata", 64'(bus.if_rdata_o), 64'(0));
    chk("t5_err",   64'(bus.err_o), 64'(1));
    bus.if_req_i = 1'b0;
    step(); step(); step();
    chk("t5_err_sticky", 64'(bus.err_o), 64'(1));

    // Reset in the middle of an access.
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h14;
    step(); step();
    chk("t6_busy", 64'(bus.mem_req_o), 64'(1));
    rst = 1'b1;
    #1;
    chk("t6_async_drop", 64'(bus.mem_req_o), 64'(0));
    chk("t6_no_ack",     64'(bus.if_ack_o), 64'(0));
    step();
    rsp_delay = 0;
    rst = 1'b0;
    chk("t6_err_clear", 64'(bus.err_o), 64'(0));
    wait_ack(10, who, cyc, busy_n, we_n);
    chk("t6_who", 64'(who), 64'(1));
    chk("t6_lat", 64'(cyc), 64'(2));
    bus.if_req_i = 1'b0;
    step();

    // start_i dropping mid-access: completes, then no further grants.
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h30; rsp_delay = 2;
    step();
    bus.start_i = 1'b0;
    wait_ack(10, who, cyc, busy_n, we_n);
    chk("t7_who", 64'(who), 64'(1));
    chk("t7_lat", 64'(cyc), 64'(3));
    busy_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.mem_req_o) busy_cnt++;
    end
    chk("t7_no_grant", 64'(busy_cnt), 64'(0));
    bus.if_req_i = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
